// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO constants and helpers
// Purpose: default word width / depth shared by the single- and dual-clock
//          FIFOs, plus a constant-foldable clog2 for address sizing.
// Ports:   none (package).
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 24;
    localparam int FIFO_DEPTH      = 16;

    // Smallest r with 2**r >= n; used at elaboration time for pointer widths.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - simple dual-port FIFO storage with registered read port
// Purpose: DATA_WIDTH x DEPTH memory, one write port, one registered read
//          port. The read register doubles as the FIFO's dout register and is
//          the only part that is reset; the array itself is not.
// Ports:   clk, rst_n (async active-low, read register only),
//          wr_en/wr_addr/wr_data (write port),
//          rd_en/rd_addr (read request), rd_data (registered read data).
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int ADDR_W     = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read register holds its value when no read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo_ctl.sv
// rtl/sync_fifo_ctl.sv - single-clock FIFO with count, programmable flags and optional FWFT
// Purpose: pointer, occupancy and flag logic around fifo_ram. All flags are
//          registered from the next-state count so they are valid one cycle
//          after the edge that caused them.
// Macro:   SYNC_FIFO_FWFT_EN selects first-word-fall-through read mode; when
//          undefined the standard (read-then-data) mode is built.
// Ports:   clk, reset_n (async active-low), wr_en/din (write), rd_en (read or
//          FWFT head acknowledge), dout, full, empty, almost_full,
//          almost_empty, count (0..DEPTH), overflow/underflow (1-cycle pulses).
module sync_fifo_ctl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 2,
    parameter int ADDR_W     = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_W:0]       count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CNT_W = ADDR_W + 1;

    if (DEPTH < 2 || DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("sync_fifo_ctl: DEPTH must be a power of two and >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH - 1) begin : g_bad_af
        $error("sync_fifo_ctl: AF_THRESH out of range 1..DEPTH-1");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_ctl: AE_THRESH out of range 0..DEPTH-1");
    end

    logic [CNT_W-1:0]      r_wptr;
    logic [CNT_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almost_full;
    logic                  r_almost_empty;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_ram_rd;
    logic                  w_empty_nxt;
    logic [CNT_W-1:0]      w_count_nxt;
    logic [DATA_WIDTH-1:0] w_ram_dout;

    // Acceptance uses start-of-cycle flags, so a read+write when full drops
    // the write and a read+write when empty drops the read.
    assign w_wr_acc = wr_en & ~r_full;
    assign w_rd_acc = rd_en & ~r_empty;

`ifdef SYNC_FIFO_FWFT_EN
    // In FWFT mode ~empty is the "dout holds a valid word" bit and count
    // includes that word, so words still in the RAM = count - ~empty.
    logic w_ram_has;
    assign w_ram_has   = r_count > {{ADDR_W{1'b0}}, ~r_empty};
    // Prefetch into the output register when it is free or being popped.
    assign w_ram_rd    = w_ram_has & (r_empty | w_rd_acc);
    assign w_empty_nxt = ~(w_ram_rd | (~r_empty & ~w_rd_acc));
`else
    assign w_ram_rd    = w_rd_acc;
    assign w_empty_nxt = (w_count_nxt == '0);
`endif

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + CNT_W'(1);
            end
            if (w_ram_rd) begin
                r_rptr <= r_rptr + CNT_W'(1);
            end
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty        <= w_empty_nxt;
            r_almost_full  <= (w_count_nxt >= CNT_W'(AF_THRESH));
            r_almost_empty <= (w_count_nxt <= CNT_W'(AE_THRESH));
            r_overflow     <= wr_en & r_full;
            r_underflow    <= rd_en & r_empty;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (reset_n),
        .wr_en   (w_wr_acc),
        .wr_addr (r_wptr[ADDR_W-1:0]),
        .wr_data (din),
        .rd_en   (w_ram_rd),
        .rd_addr (r_rptr[ADDR_W-1:0]),
        .rd_data (w_ram_dout)
    );

    assign dout         = w_ram_dout;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// tb/tb_sync_fifo_ctl.sv - directed self-checking bench for sync_fifo_ctl
module tb_sync_fifo_ctl;

    localparam int DW = 8;
    localparam int DEPTH = 8;

    logic          clk;
    logic          reset_n;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [3:0]    count;
    logic          overflow;
    logic          underflow;

    int n_tests = 0;
    int n_fail  = 0;

    sync_fifo_ctl #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_THRESH  (6),
        .AE_THRESH  (1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] wv;
        logic [7:0] rv;

        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        din     = '0;
        cyc();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ae", 32'(almost_empty), 32'd1);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_udf", 32'(underflow), 32'd0);
        reset_n = 1'b1;

`ifdef SYNC_FIFO_FWFT_EN
        wr_en = 1'b1; din = 8'h3C;
        cyc();
        wr_en = 1'b0;
        chk("fwft_e1_empty", 32'(empty), 32'd1);
        chk("fwft_e1_count", 32'(count), 32'd1);
        cyc();
        chk("fwft_e2_empty", 32'(empty), 32'd0);
        chk("fwft_e2_dout", 32'(dout), 32'h3C);
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        chk("fwft_ack_empty", 32'(empty), 32'd1);
        chk("fwft_ack_count", 32'(count), 32'd0);
`else
        // Reset mid-stream: 3 writes, one read, then async reset.
        wr_en = 1'b1;
        din = 8'h11; cyc();
        din = 8'h22; cyc();
        din = 8'h33; cyc();
        wr_en = 1'b0;
        chk("ms_count3", 32'(count), 32'd3);
        rd_en = 1'b1; cyc(); rd_en = 1'b0;
        chk("ms_dout11", 32'(dout), 32'h11);
        chk("ms_count2", 32'(count), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ms_async_count", 32'(count), 32'd0);
        chk("ms_async_empty", 32'(empty), 32'd1);
        chk("ms_async_ae", 32'(almost_empty), 32'd1);
        chk("ms_async_dout", 32'(dout), 32'd0);
        cyc();
        reset_n = 1'b1;
        rd_en = 1'b1; cyc(); rd_en = 1'b0;
        chk("ms_udf", 32'(underflow), 32'd1);
        chk("ms_udf_count", 32'(count), 32'd0);
        chk("ms_udf_dout", 32'(dout), 32'd0);
        cyc();
        chk("ms_udf_pulse", 32'(underflow), 32'd0);

        // Fill 0x01..0x08, then overflow with 0xFF.
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; din = 8'(i + 1);
            cyc();
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_af", 32'(almost_full), 32'(i + 1 >= 6));
            chk("fill_full", 32'(full), 32'(i + 1 == 8));
            chk("fill_empty", 32'(empty), 32'd0);
        end
        din = 8'hFF;
        cyc();
        wr_en = 1'b0;
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_full", 32'(full), 32'd1);
        cyc();
        chk("ovf_clear", 32'(overflow), 32'd0);
        chk("ovf_count_hold", 32'(count), 32'd8);

        // Full with read+write: read wins, 0xAA dropped.
        rd_en = 1'b1; wr_en = 1'b1; din = 8'hAA;
        cyc();
        wr_en = 1'b0;
        chk("fullrw_count", 32'(count), 32'd7);
        chk("fullrw_dout", 32'(dout), 32'h01);
        chk("fullrw_ovf", 32'(overflow), 32'd1);
        chk("fullrw_full", 32'(full), 32'd0);

        // Drain the remaining 0x02..0x08.
        for (int i = 2; i <= 8; i++) begin
            cyc();
            chk("drain_dout", 32'(dout), 32'(i));
            chk("drain_count", 32'(count), 32'(8 - i));
            chk("drain_ae", 32'(almost_empty), 32'(8 - i <= 1));
            chk("drain_af", 32'(almost_full), 32'(8 - i >= 6));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        cyc();
        rd_en = 1'b0;
        chk("drain_udf", 32'(underflow), 32'd1);
        chk("drain_dout_hold", 32'(dout), 32'h08);

        // Empty with read+write: write wins.
        rd_en = 1'b1; wr_en = 1'b1; din = 8'h55;
        cyc();
        wr_en = 1'b0;
        chk("emptyrw_count", 32'(count), 32'd1);
        chk("emptyrw_udf", 32'(underflow), 32'd1);
        chk("emptyrw_empty", 32'(empty), 32'd0);
        chk("emptyrw_dout_hold", 32'(dout), 32'h08);
        cyc();
        rd_en = 1'b0;
        chk("emptyrw_read", 32'(dout), 32'h55);
        chk("emptyrw_count0", 32'(count), 32'd0);
        chk("emptyrw_udf_clr", 32'(underflow), 32'd0);

        // Wrap-around streaming at count 4.
        wv = 8'h40;
        rv = 8'h40;
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = wv; wv = wv + 8'd1;
            cyc();
        end
        chk("stream_pre_count", 32'(count), 32'd4);
        rd_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            din = wv; wv = wv + 8'd1;
            cyc();
            chk("stream_dout", 32'(dout), 32'(rv));
            chk("stream_count", 32'(count), 32'd4);
            rv = rv + 8'd1;
        end
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("stream_tail", 32'(dout), 32'(rv));
            rv = rv + 8'd1;
        end
        rd_en = 1'b0;
        chk("stream_empty", 32'(empty), 32'd1);
        chk("stream_count0", 32'(count), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
